// File: rtl/mem_arbiter_if.sv
// Fetch/data request ports and single-port memory bus of the arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_kill;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   modport slave (
      input  if_req, if_addr, if_kill,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output dm_gnt, dm_rvalid, dm_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy
   );

   modport master (
      output if_req, if_addr, if_kill,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  dm_gnt, dm_rvalid, dm_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port memory, one access in flight.
// Ports: clk, rst (async active-low), bus (mem_arbiter_if.slave).
module mem_arbiter #(
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   localparam logic [2:0] LAT  = 3'(MEM_LAT);
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [3:0] starve_q, starve_d;
   logic       own_dm_q, own_dm_d;
   logic       own_we_q, own_we_d;
   logic       kill_q, kill_d;
   // Holds every output low until the first edge after reset release.
   logic       run_q;

   logic resp;
   logic can_gnt;
   logic if_win;
   logic dm_win;
   logic gnt_if;
   logic gnt_dm;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         starve_q <= '0;
         own_dm_q <= 1'b0;
         own_we_q <= 1'b0;
         kill_q   <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         own_dm_q <= own_dm_d;
         own_we_q <= own_we_d;
         kill_q   <= kill_d;
         run_q    <= 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      starve_d = starve_q;
      own_dm_d = own_dm_q;
      own_we_d = own_we_q;
      kill_d   = kill_q;

      bus.if_gnt    = 1'b0;
      bus.if_rvalid = 1'b0;
      bus.if_rdata  = '0;
      bus.dm_gnt    = 1'b0;
      bus.dm_rvalid = 1'b0;
      bus.dm_rdata  = '0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.busy      = (state_q == WAIT);

      resp    = (state_q == WAIT) && (cnt_q == 3'd1);
      can_gnt = run_q && ((state_q == IDLE) || resp);
      // Fetch only beats a pending data request once starved.
      if_win  = bus.if_req &&
                (!bus.dm_req || (starve_q == SMAX));
      dm_win  = bus.dm_req && !if_win;
      gnt_if  = can_gnt && if_win;
      gnt_dm  = can_gnt && dm_win;

      bus.if_gnt = gnt_if;
      bus.dm_gnt = gnt_dm;

      if (gnt_dm) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.dm_we;
         bus.mem_addr  = bus.dm_addr;
         bus.mem_wdata = bus.dm_wdata;
      end else if (gnt_if) begin
         bus.mem_en    = 1'b1;
         bus.mem_addr  = bus.if_addr;
      end

      if (resp && run_q) begin
         if (own_dm_q) begin
            bus.dm_rvalid = 1'b1;
            bus.dm_rdata  = own_we_q ? '0 : bus.mem_rdata;
         end else if (!(kill_q || bus.if_kill)) begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.mem_rdata;
         end
      end

      // A killed fetch still runs out its latency.
      if (state_q == WAIT) begin
         cnt_d  = cnt_q - 3'd1;
         kill_d = kill_q | (!own_dm_q && bus.if_kill);
      end

      if (resp) begin
         state_d = IDLE;
         cnt_d   = '0;
         kill_d  = 1'b0;
      end

      if (gnt_if || gnt_dm) begin
         state_d  = WAIT;
         cnt_d    = LAT;
         own_dm_d = gnt_dm;
         own_we_d = gnt_dm && bus.dm_we;
         kill_d   = gnt_if && bus.if_kill;
      end

      if (!bus.if_req || gnt_if)
         starve_d = '0;
      else if (gnt_dm && (starve_q != SMAX))
         starve_d = starve_q + 4'd1;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter (MEM_LAT=2, STARVE_MAX=3).
// Reference model predicts grants/responses; monitor checks responses.
module tb_mem_arbiter;

   localparam int LAT  = 2;
   localparam int SMAX = 3;
   localparam int NCYC = 3000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter #(
      .MEM_LAT(LAT),
      .STARVE_MAX(SMAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      bit          dm;
      logic [31:0] data;
      bit          killed;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   bit   m_if_gnt = 0;
   bit   m_dm_gnt = 0;
   bit   done = 0;

   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] dev_mem [logic [31:0]];
   logic [31:0] rd_pipe [LAT];

   function automatic logic [31:0] seed_word(logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'h200 + 32'($urandom % 8) * 4;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory device: read data appears LAT cycles after the strobe.
   assign bus.mem_rdata = rd_pipe[LAT-1];

   initial begin
      logic        en, we;
      logic [31:0] a, wd;
      for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
      while (!done) begin
         @(negedge clk);
         en = bus.mem_en;
         we = bus.mem_we;
         a  = bus.mem_addr;
         wd = bus.mem_wdata;
         @(posedge clk);
         #1;
         for (int i = LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
         if (en && !we)
            rd_pipe[0] = dev_mem.exists(a) ? dev_mem[a] : seed_word(a);
         else
            rd_pipe[0] = $urandom;
         if (en && we) dev_mem[a] = wd;
      end
   end

   // Reference model: one access in flight, data-first with starvation cap.
   bit          live = 0;
   bit          active;
   int          out_due = -1;
   bit          out_if = 0;
   int          starve = 0;
   bit          outstanding, free, win_if, win_dm;
   exp_t        e;

   initial begin
      while (!done) begin
         @(negedge clk);
         m_if_gnt = 0;
         m_dm_gnt = 0;
         if (!rst) begin
            live = 0;
            active = 0;
            out_due = -1;
            starve = 0;
            exp_q.delete();
         end else begin
            active = live;
            live = 1;
         end
         if (!active) begin
            chk("quiet_ctl", 32'({bus.if_gnt, bus.dm_gnt, bus.mem_en,
                bus.mem_we, bus.busy, bus.if_rvalid, bus.dm_rvalid}), 0);
            chk("quiet_if_rdata", bus.if_rdata, 0);
            chk("quiet_dm_rdata", bus.dm_rdata, 0);
         end else begin
            outstanding = (out_due >= cyc);
            free = !outstanding || (out_due == cyc);
            chk("busy", 32'(bus.busy), 32'(outstanding));
            if (outstanding && out_if && bus.if_kill && exp_q.size() > 0)
               exp_q[$].killed = 1;
            win_if = free && bus.if_req && (!bus.dm_req || starve == SMAX);
            win_dm = free && bus.dm_req && !win_if;
            if (!bus.if_req || win_if) starve = 0;
            else if (win_dm && starve < SMAX) starve++;
            chk("if_gnt", 32'(bus.if_gnt), 32'(win_if));
            chk("dm_gnt", 32'(bus.dm_gnt), 32'(win_dm));
            chk("mem_en", 32'(bus.mem_en), 32'(win_if || win_dm));
            chk("mem_we", 32'(bus.mem_we), 32'(win_dm && bus.dm_we));
            if (win_if) chk("mem_addr_if", bus.mem_addr, bus.if_addr);
            if (win_dm) begin
               chk("mem_addr_dm", bus.mem_addr, bus.dm_addr);
               chk("mem_wdata", bus.mem_wdata, bus.dm_wdata);
            end
            if (win_if || win_dm) begin
               e.dm = win_dm;
               e.due = cyc + LAT;
               e.killed = win_if && bus.if_kill;
               if (win_dm && bus.dm_we) begin
                  ref_mem[bus.dm_addr] = bus.dm_wdata;
                  e.data = '0;
               end else begin
                  a_lookup();
               end
               exp_q.push_back(e);
               out_due = e.due;
               out_if = win_if;
            end
            m_if_gnt = win_if;
            m_dm_gnt = win_dm;
         end
      end
   end

   task automatic a_lookup();
      logic [31:0] a;
      a = win_dm ? bus.dm_addr : bus.if_addr;
      e.data = ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
   endtask

   // Monitor: pops the expected response when it falls due.
   initial begin
      bit   got_if, got_dm;
      exp_t r;
      while (!done) begin
         @(negedge clk);
         #2;
         got_if = bus.if_rvalid;
         got_dm = bus.dm_rvalid;
         if (!got_if) chk("if_rdata_idle", bus.if_rdata, 0);
         if (!got_dm) chk("dm_rdata_idle", bus.dm_rdata, 0);
         if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            r = exp_q.pop_front();
            if (r.dm) begin
               chk("dm_rvalid", 32'(got_dm), 1);
               if (got_dm) chk("dm_rdata", bus.dm_rdata, r.data);
               got_dm = 0;
            end else if (r.killed) begin
               chk("if_kill_suppress", 32'(got_if), 0);
               got_if = 0;
            end else begin
               chk("if_rvalid", 32'(got_if), 1);
               if (got_if) chk("if_rdata", bus.if_rdata, r.data);
               got_if = 0;
            end
         end
         if (rst) begin
            chk("if_rvalid_extra", 32'(got_if), 0);
            chk("dm_rvalid_extra", 32'(got_dm), 0);
         end
      end
   end

   // Stimulus: requests held until the model says granted.
   initial begin
      bus.if_req = 0;
      bus.if_addr = '0;
      bus.if_kill = 0;
      bus.dm_req = 0;
      bus.dm_we = 0;
      bus.dm_addr = '0;
      bus.dm_wdata = '0;
      #1 rst = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1;
      for (int k = 0; k < NCYC; k++) begin
         @(posedge clk);
         #1;
         if (m_if_gnt) bus.if_req = 0;
         if (m_dm_gnt) bus.dm_req = 0;
         if (k % 700 == 350) rst = 0;
         if (k % 700 == 352) rst = 1;
         if (!rst) begin
            bus.if_req = 0;
            bus.dm_req = 0;
            bus.if_kill = 0;
         end else if (k == 0) begin
            bus.dm_req = 1;
            bus.dm_we = 1;
            bus.dm_addr = 32'h200;
            bus.dm_wdata = 32'hDEADBEEF;
         end else begin
            if (!bus.if_req && ($urandom % 4 != 0)) begin
               bus.if_req = 1;
               bus.if_addr = rand_addr();
            end
            if (!bus.dm_req && ($urandom % 3 != 0)) begin
               bus.dm_req = 1;
               bus.dm_we = 1'($urandom % 2);
               bus.dm_addr = rand_addr();
               bus.dm_wdata = $urandom;
            end
            bus.if_kill = ($urandom % 8 == 0);
         end
      end
      @(posedge clk);
      #1;
      bus.if_req = 0;
      bus.dm_req = 0;
      bus.if_kill = 0;
      repeat (LAT + 3) @(posedge clk);
      done = 1;
      @(negedge clk);
      #3;
      if (exp_q.size() != 0)
         chk("drain_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LAT, 2, cycles from grant cycle to response cycle; legal 1..7.
REQ-002 Parameter: STARVE_MAX, 3, max consecutive data-port grants while the fetch port waits; legal 1..15.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: if_req  in  1  fetch-stage read request; held until if_gnt.
REQ-006 Port: if_addr  in  32  fetch address.
REQ-007 Port: if_kill  in  1  pipeline flush; drops the outstanding fetch response.
REQ-008 Port: if_gnt  out  1  fetch request accepted this cycle.
REQ-009 Port: if_rvalid  out  1  fetch data valid this cycle.
REQ-010 Port: if_rdata  out  32  fetch data.
REQ-011 Port: dm_req  in  1  MEM-stage request; held until dm_gnt.
REQ-012 Port: dm_we  in  1  1 = write, 0 = read.
REQ-013 Port: dm_addr  in  32  data address.
REQ-014 Port: dm_wdata  in  32  write data.
REQ-015 Port: dm_gnt  out  1  data request accepted this cycle.
REQ-016 Port: dm_rvalid  out  1  read data valid, or write-complete pulse.
REQ-017 Port: dm_rdata  out  32  read data; 0 for writes.
REQ-018 Port: mem_en, mem_we  out  1 each  single-port memory strobe and write enable.
REQ-019 Port: mem_addr, mem_wdata  out  32 each  memory address and write data.
REQ-020 Port: mem_rdata  in  32  memory read data, valid exactly MEM_LAT cycles after the mem_en cycle.
REQ-021 Port: busy  out  1  a transaction is outstanding.

Function
REQ-022 FSM states: IDLE (nothing outstanding) and WAIT (one outstanding); at most one transaction is outstanding at any time.
REQ-023 Grant is combinational in the same cycle as the request; grant is allowed in IDLE, and in WAIT only in the response cycle (count = 1).
REQ-024 In a grant cycle, mem_en = 1 and mem_addr/mem_we/mem_wdata come from the winner; mem_we = 0 for fetch; in non-grant cycles mem_en = 0 and mem_we = 0.
REQ-025 Priority: dm wins when both request, unless the starve counter equals STARVE_MAX; in that case if wins.
REQ-026 Starve counter: +1 on each dm grant while if_req = 1 and not granted (saturating at STARVE_MAX); cleared on any if grant and whenever if_req = 0.
REQ-027 On a grant: latch owner and kind (read/write), load latency counter = MEM_LAT, enter WAIT; the counter decrements each cycle in WAIT.
REQ-028 Response cycle = grant cycle + MEM_LAT (counter = 1).
REQ-029 Response to a dm owner: dm_rvalid = 1; dm_rdata = mem_rdata for reads, 0 for writes.
REQ-030 Response to an if owner: if_rvalid = 1 and if_rdata = mem_rdata, unless the fetch was killed.
REQ-031 Response cycle transition: to WAIT with a fresh count on a new grant, otherwise to IDLE.
REQ-032 if_kill = 1 while an if transaction is outstanding (grant cycle included) sets a kill flag; if_kill in the response cycle also suppresses.
REQ-033 A killed fetch still consumes its full latency, and the memory slot is not reused early.
REQ-034 if_kill has no effect on dm transactions or when no fetch is outstanding.
REQ-035 *_rvalid are single-cycle pulses; *_rdata = 0 whenever the matching rvalid = 0.
REQ-036 busy = 1 in WAIT, else 0.
REQ-037 Throughput: one transaction per MEM_LAT cycles when requests are continuous.

Reset
REQ-038 rst low asynchronously forces IDLE, counters = 0, kill flag = 0, and all outputs = 0, including mid-transaction.
REQ-039 A transaction outstanding at reset never produces rvalid after reset releases.
REQ-040 Outputs stay 0 until the first edge after rst is high.

Verification (MEM_LAT=2, STARVE_MAX=3)
REQ-041 if_req, if_addr=0x40 in IDLE at cycle 0 -> if_gnt=1 and mem_en=1, mem_addr=0x40 at cycle 0; if_rvalid=1 with if_rdata=mem_rdata at cycle 2.
REQ-042 if_req and dm_req (read 0x100) both at cycle 0 -> dm_gnt at cycle 0, dm_rvalid at cycle 2; if_gnt at cycle 2 (back-to-back), if_rvalid at cycle 4.
REQ-043 dm_req held continuously with if_req held -> dm granted 3 times, 4th grant goes to if, then dm resumes.
REQ-044 dm write 0x200/0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF at grant; dm_rvalid=1 with dm_rdata=0 two cycles later.
REQ-045 Fetch granted at cycle 0, if_kill=1 at cycle 1 -> if_rvalid stays 0 at cycle 2; new grant still possible at cycle 2.
REQ-046 rst low at cycle 1 of an outstanding read -> all outputs 0 immediately; no rvalid after release; first request after release is granted from IDLE.
